calc_mem_responder: RTL and testbench

- Memory-side responder for the calculator datapath.
- Serves the controller's single-cycle read/write strobes against a DEPTH x MEM_WORD_SIZE array.
- Returns read data after a fixed, parameterised latency, with write-first forwarding on same-address collisions.
- Provides a sequential clear engine that zeroes the whole array on request. It sits between the controller and the storage macro/model.

---
 rtl/calc_mem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_calc_mem_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : calc_mem_responder
// Brief    : Memory-side responder for the calculator datapath. Serves
//            single-cycle read/write strobes against a DEPTH x MEM_WORD_SIZE
//            array, returns read data after RD_LAT cycles with write-first
//            forwarding, and provides a sequential whole-array clear engine.
// Options  : CALC_MEM_PARITY_EN adds per-word even parity storage, the
//            par_inj_i fault-injection input and the par_err_o output.
// Revision : 1.0 - initial release
// ============================================================================
module calc_mem_responder #(
    parameter int ADDR_W        = 10,
    parameter int MEM_WORD_SIZE = 64,
    parameter int DEPTH         = 1024,
    parameter int RD_LAT        = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        r_addr,
    output logic [MEM_WORD_SIZE-1:0] r_data,
    output logic                     r_valid,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [MEM_WORD_SIZE-1:0] w_data,
    input  logic                     clr_i,
    output logic                     busy_o,
    output logic                     clr_done_o,
    output logic                     oob_o,
`ifdef CALC_MEM_PARITY_EN
    input  logic                     par_inj_i,
    output logic                     par_err_o,
`endif
    output logic                     drop_o
);

    localparam int                 c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                   r_state;
    logic [c_IDX_W-1:0]       r_clr_cnt;
    logic                     r_busy;
    logic                     r_clr_done;
    logic                     r_oob;
    logic                     r_drop;

    // Storage is deliberately left out of reset so it can map onto a macro.
    logic [MEM_WORD_SIZE-1:0] r_mem [DEPTH];

    logic [MEM_WORD_SIZE-1:0] r_pipe_dat [RD_LAT];
    logic [RD_LAT-1:0]        r_pipe_vld;

    logic                     w_idle;
    logic                     w_rd_inr;
    logic                     w_wr_inr;
    logic                     w_rd_acc;
    logic                     w_wr_acc;
    logic                     w_fwd;
    logic                     w_clr_we;
    logic [c_IDX_W-1:0]       w_rd_idx;
    logic [c_IDX_W-1:0]       w_wr_idx;
    logic [MEM_WORD_SIZE-1:0] w_rd_word;

    assign w_idle   = (r_state == S_IDLE);
    assign w_rd_inr = ({1'b0, r_addr} < c_DEPTH);
    assign w_wr_inr = ({1'b0, w_addr} < c_DEPTH);
    assign w_rd_acc = read  && w_idle;
    assign w_wr_acc = write && w_idle && w_wr_inr;
    assign w_clr_we = (r_state == S_CLEAR);
    assign w_rd_idx = r_addr[c_IDX_W-1:0];
    assign w_wr_idx = w_addr[c_IDX_W-1:0];

    // Write-first: an accepted write to the read address wins over the array.
    assign w_fwd = w_wr_acc && (w_addr == r_addr);

    always_comb begin
        w_rd_word = '0;
        if (w_fwd) begin
            w_rd_word = w_data;
        end else if (w_rd_inr) begin
            w_rd_word = r_mem[w_rd_idx];
        end
    end

    // Clear engine and write port never collide: writes are dropped while busy.
    always_ff @(posedge clk_i) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc) begin
            r_mem[w_wr_idx] <= w_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_clr_cnt  <= '0;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr_i) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == c_LAST) begin
                        r_state    <= S_IDLE;
                        r_clr_cnt  <= '0;
                        r_busy     <= 1'b0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Data stages only advance with a valid token so r_data holds between reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_dat[i] <= '0;
            end
            r_oob  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_pipe_dat[0] <= w_rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                if (r_pipe_vld[i-1]) begin
                    r_pipe_dat[i] <= r_pipe_dat[i-1];
                end
            end
            r_oob  <= w_idle && ((read && !w_rd_inr) || (write && !w_wr_inr));
            r_drop <= !w_idle && (read || write);
        end
    end

    assign r_data     = r_pipe_dat[RD_LAT-1];
    assign r_valid    = r_pipe_vld[RD_LAT-1];
    assign busy_o     = r_busy;
    assign clr_done_o = r_clr_done;
    assign oob_o      = r_oob;
    assign drop_o     = r_drop;

`ifdef CALC_MEM_PARITY_EN
    logic                r_par [DEPTH];
    logic [RD_LAT-1:0]   r_pipe_perr;
    logic                w_par_bad;

    always_ff @(posedge clk_i) begin
        if (w_clr_we) begin
            r_par[r_clr_cnt] <= 1'b0;
        end else if (w_wr_acc) begin
            r_par[w_wr_idx] <= (^w_data) ^ par_inj_i;
        end
    end

    // Forwarded data never touched the array, so it cannot carry a stored error.
    assign w_par_bad = w_rd_acc && w_rd_inr && !w_fwd &&
                       ((^r_mem[w_rd_idx]) != r_par[w_rd_idx]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe_perr <= '0;
        end else begin
            r_pipe_perr[0] <= w_par_bad;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_perr[i] <= r_pipe_perr[i-1];
            end
        end
    end

    assign par_err_o = r_pipe_perr[RD_LAT-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_calc_mem_responder.sv
`default_nettype none
// Testbench for calc_mem_responder: two instances (RD_LAT=1 and RD_LAT=3,
// both DEPTH=16) share stimulus; directed vectors with hand-computed results.
module tb_calc_mem_responder;

    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int DEP = 16;
    localparam logic [DW-1:0] V5 = 64'h0000_0002_0000_0003;

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b1;
    logic          read   = 1'b0;
    logic          write  = 1'b0;
    logic          clr_i  = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;

    logic [DW-1:0] rd1, rd3;
    logic          rv1, rv3, busy1, busy3, done1, done3, oob1, oob3, drop1, drop3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

`ifdef CALC_MEM_PARITY_EN
    logic perr1, perr3;
`endif

    calc_mem_responder #(.ADDR_W(AW), .MEM_WORD_SIZE(DW), .DEPTH(DEP), .RD_LAT(1)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .read(read), .r_addr(r_addr),
        .r_data(rd1), .r_valid(rv1), .write(write), .w_addr(w_addr),
        .w_data(w_data), .clr_i(clr_i), .busy_o(busy1), .clr_done_o(done1),
        .oob_o(oob1),
`ifdef CALC_MEM_PARITY_EN
        .par_inj_i(1'b0), .par_err_o(perr1),
`endif
        .drop_o(drop1)
    );

    calc_mem_responder #(.ADDR_W(AW), .MEM_WORD_SIZE(DW), .DEPTH(DEP), .RD_LAT(3)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .read(read), .r_addr(r_addr),
        .r_data(rd3), .r_valid(rv3), .write(write), .w_addr(w_addr),
        .w_data(w_data), .clr_i(clr_i), .busy_o(busy3), .clr_done_o(done3),
        .oob_o(oob3),
`ifdef CALC_MEM_PARITY_EN
        .par_inj_i(1'b0), .par_err_o(perr3),
`endif
        .drop_o(drop3)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        write  = 1'b1;
        w_addr = AW'(a);
        w_data = d;
        tick();
        write  = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({rv1, busy1, done1, oob1, drop1} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags1: got %b want 00000", {rv1, busy1, done1, oob1, drop1});
        end
        n_cmp++;
        if ({rv3, busy3, done3, oob3, drop3} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags3: got %b want 00000", {rv3, busy3, done3, oob3, drop3});
        end
        n_cmp++;
        if (rd1 !== '0 || rd3 !== '0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h / %h want 0", rd1, rd3);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        do_write(5, V5);
        read = 1'b1; r_addr = 10'd5;
        tick();
        read = 1'b0;
        n_cmp++;
        if (rv1 !== 1'b1 || rd1 !== V5) begin
            n_bad++;
            $display("FAIL wr_rd_lat1: got v=%b d=%h want v=1 d=%h", rv1, rd1, V5);
        end
        n_cmp++;
        if (rv3 !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rd_lat3_early: got v=%b want 0", rv3);
        end
        tick();
        n_cmp++;
        if (rv1 !== 1'b0 || rd1 !== V5) begin
            n_bad++;
            $display("FAIL rdata_hold: got v=%b d=%h want v=0 d=%h", rv1, rd1, V5);
        end
        tick();
        n_cmp++;
        if (rv3 !== 1'b1 || rd3 !== V5) begin
            n_bad++;
            $display("FAIL wr_rd_lat3: got v=%b d=%h want v=1 d=%h", rv3, rd3, V5);
        end
        tick();
    endtask

    task automatic test_latency3();
        do_write(0, 64'd10);
        do_write(1, 64'd11);
        do_write(2, 64'd12);
        for (int k = 0; k < 6; k++) begin
            read   = (k < 3);
            r_addr = AW'(k);
            tick();
            read = 1'b0;
            n_cmp++;
            if (rv3 !== (k >= 2 && k <= 4) ||
                ((k >= 2) && rd3 !== 64'(10 + ((k > 4) ? 2 : k - 2)))) begin
                n_bad++;
                $display("FAIL lat3_k%0d: got v=%b d=%0d", k, rv3, rd3);
            end
            n_cmp++;
            if (rv1 !== (k < 3) || ((k < 3) && rd1 !== 64'(10 + k))) begin
                n_bad++;
                $display("FAIL lat1_k%0d: got v=%b d=%0d", k, rv1, rd1);
            end
        end
    endtask

    task automatic test_collision();
        do_write(7, 64'hAA);
        read = 1'b1; r_addr = 10'd7;
        write = 1'b1; w_addr = 10'd7; w_data = 64'h55;
        tick();
        read = 1'b0; w_data = 64'h99;
        n_cmp++;
        if (rv1 !== 1'b1 || rd1 !== 64'h55) begin
            n_bad++;
            $display("FAIL collision_fwd: got v=%b d=%h want v=1 d=55", rv1, rd1);
        end
        tick();
        write = 1'b0;
        tick();
        n_cmp++;
        if (rv3 !== 1'b1 || rd3 !== 64'h55) begin
            n_bad++;
            $display("FAIL collision_inflight: got v=%b d=%h want v=1 d=55", rv3, rd3);
        end
        read = 1'b1; r_addr = 10'd7;
        tick();
        read = 1'b0;
        n_cmp++;
        if (rv1 !== 1'b1 || rd1 !== 64'h99) begin
            n_bad++;
            $display("FAIL collision_later_wr: got v=%b d=%h want v=1 d=99", rv1, rd1);
        end
        read = 1'b1; r_addr = 10'd5;
        write = 1'b1; w_addr = 10'd9; w_data = 64'h1234;
        tick();
        read = 1'b0; write = 1'b0;
        n_cmp++;
        if (rd1 !== V5) begin
            n_bad++;
            $display("FAIL diff_addr_rd: got %h want %h", rd1, V5);
        end
        read = 1'b1; r_addr = 10'd9;
        tick();
        read = 1'b0;
        n_cmp++;
        if (rd1 !== 64'h1234) begin
            n_bad++;
            $display("FAIL diff_addr_wr: got %h want 1234", rd1);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_oob();
        do_write(4, 64'h44);
        n_cmp++;
        if (oob1 !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_inrange: got %b want 0", oob1);
        end
        write = 1'b1; w_addr = 10'd20; w_data = 64'hDEAD;
        tick();
        write = 1'b0;
        n_cmp++;
        if (oob1 !== 1'b1) begin
            n_bad++;
            $display("FAIL oob_write_pulse: got %b want 1", oob1);
        end
        tick();
        n_cmp++;
        if (oob1 !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_pulse_end: got %b want 0", oob1);
        end
        read = 1'b1; r_addr = 10'd20;
        tick();
        read = 1'b0;
        n_cmp++;
        if (rv1 !== 1'b1 || rd1 !== '0 || oob1 !== 1'b1) begin
            n_bad++;
            $display("FAIL oob_read: got v=%b d=%h oob=%b want v=1 d=0 oob=1", rv1, rd1, oob1);
        end
        read = 1'b1; r_addr = 10'd20; write = 1'b1; w_addr = 10'd30;
        tick();
        read = 1'b0; write = 1'b0;
        tick();
        n_cmp++;
        if (oob1 !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_single_pulse: got %b want 0", oob1);
        end
        read = 1'b1; r_addr = 10'd4;
        tick();
        read = 1'b0;
        n_cmp++;
        if (rd1 !== 64'h44) begin
            n_bad++;
            $display("FAIL oob_array_intact: got %h want 44", rd1);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_clear();
        int busy_cnt, done_cnt, done_at, vcnt, drop_cnt;
        busy_cnt = 0; done_cnt = 0; done_at = 0; vcnt = 0; drop_cnt = 0;
        for (int i = 0; i < DEP; i++) do_write(i, 64'hFF);
        clr_i = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            clr_i = 1'b0; read = 1'b0; write = 1'b0;
            if (busy1) busy_cnt++;
            if (done1) begin done_cnt++; done_at = t; end
            if (rv1) vcnt++;
            if (drop1) drop_cnt++;
            if (t == 1) begin read = 1'b1; r_addr = 10'd3; end
            if (t == 3) begin write = 1'b1; w_addr = 10'd0; w_data = 64'h77; end
            if (t == 5) clr_i = 1'b1;
        end
        n_cmp++;
        if (busy_cnt != DEP) begin
            n_bad++;
            $display("FAIL clear_busy_len: got %0d want %0d", busy_cnt, DEP);
        end
        n_cmp++;
        if (done_cnt != 1 || done_at != DEP + 1) begin
            n_bad++;
            $display("FAIL clear_done: got cnt=%0d at=%0d want cnt=1 at=%0d", done_cnt, done_at, DEP + 1);
        end
        n_cmp++;
        if (vcnt != 0 || drop_cnt != 2) begin
            n_bad++;
            $display("FAIL clear_drop: got valids=%0d drops=%0d want 0/2", vcnt, drop_cnt);
        end
        for (int i = 0; i < DEP; i++) begin
            read = 1'b1; r_addr = AW'(i);
            tick();
            read = 1'b0;
            n_cmp++;
            if (rv1 !== 1'b1 || rd1 !== '0) begin
                n_bad++;
                $display("FAIL cleared_word%0d: got v=%b d=%h want v=1 d=0", i, rv1, rd1);
            end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_clear();
        int done_cnt;
        logic [DW-1:0] exp;
        done_cnt = 0;
        for (int i = 0; i < DEP; i++) do_write(i, 64'hFF);
        clr_i = 1'b1;
        write = 1'b1; w_addr = 10'd15; w_data = 64'hAB;
        tick();
        clr_i = 1'b0; write = 1'b0;
        for (int t = 2; t <= 9; t++) tick();
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_busy: got %b/%b want 0/0", busy1, busy3);
        end
        tick();
        tick();
        rst_ni = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (done1 || done3 || busy1) done_cnt++;
        end
        n_cmp++;
        if (done_cnt != 0) begin
            n_bad++;
            $display("FAIL rst_mid_done: got %0d done/busy cycles want 0", done_cnt);
        end
        for (int i = 0; i < DEP; i++) begin
            exp = (i < 8) ? 64'h0 : ((i == 15) ? 64'hAB : 64'hFF);
            read = 1'b1; r_addr = AW'(i);
            tick();
            read = 1'b0;
            n_cmp++;
            if (rv1 !== 1'b1 || rd1 !== exp) begin
                n_bad++;
                $display("FAIL rst_mid_word%0d: got v=%b d=%h want v=1 d=%h", i, rv1, rd1, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency3();
        test_collision();
        test_oob();
        test_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
